// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared across the RV32I pipeline.
//   - forwarding select codes driven by the forward unit
//   - ALU operation enum
//   - canonical bubble instruction (addi x0, x0, 0)
//   - opcode / funct3 constants used by the execute stage
//   - write-back source select encoding
package riscv_pkg;

   localparam logic [1:0] NO_FORWARD  = 2'b00;
   localparam logic [1:0] MEM_FORWARD = 2'b01;
   localparam logic [1:0] WB_FORWARD  = 2'b10;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

endpackage

// File: rtl/alu.sv
// alu: purely combinational RV32I ALU.
//   op_a, op_b : operands
//   op         : operation (alu_op_e)
//   result     : op_a <op> op_b; shifts use op_b[4:0]; unknown ops give 0
module alu
   import riscv_pkg::*;
(
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  alu_op_e     op,
   output logic [31:0] result
);

   logic [4:0] shamt;
   assign shamt = op_b[4:0];

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:    result = op_a + op_b;
         ALU_SUB:    result = op_a - op_b;
         ALU_SLL:    result = op_a << shamt;
         ALU_SLT:    result = {31'b0, $signed(op_a) < $signed(op_b)};
         ALU_SLTU:   result = {31'b0, op_a < op_b};
         ALU_XOR:    result = op_a ^ op_b;
         ALU_SRL:    result = op_a >> shamt;
         ALU_SRA:    result = $unsigned($signed(op_a) >>> shamt);
         ALU_OR:     result = op_a | op_b;
         ALU_AND:    result = op_a & op_b;
         ALU_PASS_B: result = op_b;
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32I pipeline.
//   Inputs : EX-slot instruction/pc/valid, register data, immediate, ALU op and
//            operand selects, carried-forward enables, forwarding selects,
//            WB write-back value, stall and flush.
//   Outputs: br_taken_EX / br_target_EX (combinational redirect) and the
//            EX/MEM pipeline register (*_MEM).
//   The MEM forwarding source is this stage's own registered alu_data_MEM.
module ex_stage
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_EX,
   input  logic [31:0] pc_EX,
   input  logic        valid_EX,
   input  logic [31:0] rs1_data_EX,
   input  logic [31:0] rs2_data_EX,
   input  logic [31:0] imm_EX,
   input  logic [3:0]  alu_op_EX,
   input  logic        a_sel_EX,
   input  logic        b_sel_EX,
   input  logic        rd_wren_EX,
   input  logic        mem_wren_EX,
   input  logic [1:0]  wb_sel_EX,
   input  logic [1:0]  forward_ASel,
   input  logic [1:0]  forward_BSel,
   input  logic [31:0] wb_data_WB,
   input  logic        stall,
   input  logic        flush,
   output logic        br_taken_EX,
   output logic [31:0] br_target_EX,
   output logic [31:0] instr_MEM,
   output logic [31:0] pc_MEM,
   output logic [31:0] alu_data_MEM,
   output logic [31:0] store_data_MEM,
   output logic        rd_wren_MEM,
   output logic        mem_wren_MEM,
   output logic        valid_MEM,
   output logic [1:0]  wb_sel_MEM
);

   logic [31:0] instr_reg, pc_reg, alu_data_reg, store_data_reg;
   logic        rd_wren_reg, mem_wren_reg, valid_reg;
   logic [1:0]  wb_sel_reg;

   logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_result, ex_result;
   logic [31:0] pc_target, jalr_target;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_branch, is_jal, is_jalr, br_cond;

   // Operand forwarding; code 11 falls through to the register-file value.
   always_comb begin
      fwd_a = rs1_data_EX;
      case (forward_ASel)
         MEM_FORWARD: fwd_a = alu_data_reg;
         WB_FORWARD:  fwd_a = wb_data_WB;
         default:     fwd_a = rs1_data_EX;
      endcase
   end

   always_comb begin
      fwd_b = rs2_data_EX;
      case (forward_BSel)
         MEM_FORWARD: fwd_b = alu_data_reg;
         WB_FORWARD:  fwd_b = wb_data_WB;
         default:     fwd_b = rs2_data_EX;
      endcase
   end

   assign op_a = a_sel_EX ? pc_EX  : fwd_a;
   assign op_b = b_sel_EX ? imm_EX : fwd_b;

   alu u_alu (
      .op_a   (op_a),
      .op_b   (op_b),
      .op     (alu_op_e'(alu_op_EX)),
      .result (alu_result)
   );

   assign opcode    = instr_EX[6:0];
   assign funct3    = instr_EX[14:12];
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);

   // Branch compare always uses the forwarded registers, never the ALU operands.
   always_comb begin
      br_cond = 1'b0;
      case (funct3)
         F3_BEQ:  br_cond = (fwd_a == fwd_b);
         F3_BNE:  br_cond = (fwd_a != fwd_b);
         F3_BLT:  br_cond = ($signed(fwd_a) <  $signed(fwd_b));
         F3_BGE:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
         F3_BLTU: br_cond = (fwd_a <  fwd_b);
         F3_BGEU: br_cond = (fwd_a >= fwd_b);
         default: br_cond = 1'b0;
      endcase
   end

   assign pc_target   = pc_EX + imm_EX;
   assign jalr_target = (fwd_a + imm_EX) & ~32'h1;

   assign br_taken_EX  = valid_EX & ~flush & ((is_branch & br_cond) | is_jal | is_jalr);
   assign br_target_EX = is_jalr ? jalr_target : pc_target;

   // Jumps write the link address instead of the ALU result.
   assign ex_result = (is_jal | is_jalr) ? (pc_EX + 32'd4) : alu_result;

   // EX/MEM register: reset/flush load a bubble, flush beats stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_reg      <= NOP_INSTR;
         pc_reg         <= '0;
         alu_data_reg   <= '0;
         store_data_reg <= '0;
         rd_wren_reg    <= 1'b0;
         mem_wren_reg   <= 1'b0;
         valid_reg      <= 1'b0;
         wb_sel_reg     <= '0;
      end else if (flush) begin
         instr_reg      <= NOP_INSTR;
         pc_reg         <= '0;
         alu_data_reg   <= '0;
         store_data_reg <= '0;
         rd_wren_reg    <= 1'b0;
         mem_wren_reg   <= 1'b0;
         valid_reg      <= 1'b0;
         wb_sel_reg     <= '0;
      end else if (!stall) begin
         instr_reg      <= instr_EX;
         pc_reg         <= pc_EX;
         alu_data_reg   <= ex_result;
         store_data_reg <= fwd_b;
         rd_wren_reg    <= rd_wren_EX & valid_EX;
         mem_wren_reg   <= mem_wren_EX & valid_EX;
         valid_reg      <= valid_EX;
         wb_sel_reg     <= wb_sel_EX;
      end
   end

   assign instr_MEM      = instr_reg;
   assign pc_MEM         = pc_reg;
   assign alu_data_MEM   = alu_data_reg;
   assign store_data_MEM = store_data_reg;
   assign rd_wren_MEM    = rd_wren_reg;
   assign mem_wren_MEM   = mem_wren_reg;
   assign valid_MEM      = valid_reg;
   assign wb_sel_MEM     = wb_sel_reg;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed literal checks plus randomized traffic compared every
// cycle against a behavioural model of the execute stage.
module tb_ex_stage;
   import riscv_pkg::*;

   logic        clk, rst;
   logic [31:0] instr_EX, pc_EX, rs1_data_EX, rs2_data_EX, imm_EX, wb_data_WB;
   logic        valid_EX, a_sel_EX, b_sel_EX, rd_wren_EX, mem_wren_EX, stall, flush;
   logic [3:0]  alu_op_EX;
   logic [1:0]  wb_sel_EX, forward_ASel, forward_BSel;
   logic        br_taken_EX;
   logic [31:0] br_target_EX, instr_MEM, pc_MEM, alu_data_MEM, store_data_MEM;
   logic        rd_wren_MEM, mem_wren_MEM, valid_MEM;
   logic [1:0]  wb_sel_MEM;

   int errors = 0;
   int checks = 0;
   int txn    = 0;

   ex_stage dut (
      .clk(clk), .rst(rst),
      .instr_EX(instr_EX), .pc_EX(pc_EX), .valid_EX(valid_EX),
      .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX), .imm_EX(imm_EX),
      .alu_op_EX(alu_op_EX), .a_sel_EX(a_sel_EX), .b_sel_EX(b_sel_EX),
      .rd_wren_EX(rd_wren_EX), .mem_wren_EX(mem_wren_EX), .wb_sel_EX(wb_sel_EX),
      .forward_ASel(forward_ASel), .forward_BSel(forward_BSel),
      .wb_data_WB(wb_data_WB), .stall(stall), .flush(flush),
      .br_taken_EX(br_taken_EX), .br_target_EX(br_target_EX),
      .instr_MEM(instr_MEM), .pc_MEM(pc_MEM), .alu_data_MEM(alu_data_MEM),
      .store_data_MEM(store_data_MEM), .rd_wren_MEM(rd_wren_MEM),
      .mem_wren_MEM(mem_wren_MEM), .valid_MEM(valid_MEM), .wb_sel_MEM(wb_sel_MEM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_instr, m_pc, m_alu, m_store;
   logic        m_rd, m_mem, m_valid;
   logic [1:0]  m_wbsel;

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
      if (sel == 2'b01) return m_alu;
      if (sel == 2'b10) return wb_data_WB;
      return rf;
   endfunction

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sa, sb;
      int unsigned sh;
      sa = int'(a);
      sb = int'(b);
      sh = b % 32;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a << sh;
         4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd4:  return (a < b) ? 32'd1 : 32'd0;
         4'd5:  return a ^ b;
         4'd6:  return a >> sh;
         4'd7:  return 32'(sa >>> sh);
         4'd8:  return a | b;
         4'd9:  return a & b;
         4'd10: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic is_jump();
      return (instr_EX[6:0] == 7'b1101111) || (instr_EX[6:0] == 7'b1100111);
   endfunction

   function automatic logic exp_taken();
      logic [31:0] a, b;
      logic        c;
      a = pick(forward_ASel, rs1_data_EX);
      b = pick(forward_BSel, rs2_data_EX);
      c = 1'b0;
      if (!valid_EX || flush) return 1'b0;
      if (is_jump()) return 1'b1;
      if (instr_EX[6:0] != 7'b1100011) return 1'b0;
      case (instr_EX[14:12])
         3'd0: c = (a == b);
         3'd1: c = (a != b);
         3'd4: c = (int'(a) <  int'(b));
         3'd5: c = (int'(a) >= int'(b));
         3'd6: c = (a < b);
         3'd7: c = (a >= b);
         default: c = 1'b0;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] exp_target();
      if (instr_EX[6:0] == 7'b1100111)
         return (pick(forward_ASel, rs1_data_EX) + imm_EX) & 32'hFFFF_FFFE;
      return pc_EX + imm_EX;
   endfunction

   function automatic logic [31:0] exp_result();
      logic [31:0] a, b;
      if (is_jump()) return pc_EX + 32'd4;
      a = a_sel_EX ? pc_EX : pick(forward_ASel, rs1_data_EX);
      b = b_sel_EX ? imm_EX : pick(forward_BSel, rs2_data_EX);
      return alu_ref(alu_op_EX, a, b);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst || (!rst && flush)) begin
         m_instr <= 32'h0000_0013; m_pc <= '0; m_alu <= '0; m_store <= '0;
         m_rd <= 1'b0; m_mem <= 1'b0; m_valid <= 1'b0; m_wbsel <= '0;
      end else if (!stall) begin
         m_instr <= instr_EX;
         m_pc    <= pc_EX;
         m_alu   <= exp_result();
         m_store <= pick(forward_BSel, rs2_data_EX);
         m_rd    <= rd_wren_EX && valid_EX;
         m_mem   <= mem_wren_EX && valid_EX;
         m_valid <= valid_EX;
         m_wbsel <= wb_sel_EX;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         txn++;
         $display("txn %0d: instr=%h pc=%h alu=%h store=%h v=%b br=%b", txn,
                  instr_MEM, pc_MEM, alu_data_MEM, store_data_MEM, valid_MEM, br_taken_EX);
         chk("br_taken", 32'(br_taken_EX), 32'(exp_taken()));
         if (exp_taken()) chk("br_target", br_target_EX, exp_target());
         chk("instr_MEM", instr_MEM, m_instr);
         chk("pc_MEM", pc_MEM, m_pc);
         chk("alu_data_MEM", alu_data_MEM, m_alu);
         chk("store_data_MEM", store_data_MEM, m_store);
         chk("rd_wren_MEM", 32'(rd_wren_MEM), 32'(m_rd));
         chk("mem_wren_MEM", 32'(mem_wren_MEM), 32'(m_mem));
         chk("valid_MEM", 32'(valid_MEM), 32'(m_valid));
         chk("wb_sel_MEM", 32'(wb_sel_MEM), 32'(m_wbsel));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      instr_EX = 32'h0000_0033; pc_EX = 32'h0; valid_EX = 1'b1;
      rs1_data_EX = '0; rs2_data_EX = '0; imm_EX = '0; wb_data_WB = '0;
      alu_op_EX = ALU_ADD; a_sel_EX = 1'b0; b_sel_EX = 1'b0;
      rd_wren_EX = 1'b0; mem_wren_EX = 1'b0; wb_sel_EX = 2'd0;
      forward_ASel = 2'b00; forward_BSel = 2'b00; stall = 1'b0; flush = 1'b0;
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return $urandom_range(0, 40);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] tmp;
      logic [6:0]  opc;
      set_idle();
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      $display("directed: power-on reset");
      chk("reset_instr", instr_MEM, 32'h0000_0013);
      chk("reset_valid", 32'(valid_MEM), 32'd0);
      chk("reset_alu", alu_data_MEM, 32'd0);
      @(negedge clk); #1 rst = 1'b0;

      // MEM forwarding
      rs1_data_EX = 32'd5; b_sel_EX = 1'b1; imm_EX = 32'd0; rd_wren_EX = 1'b1;
      tick();
      $display("directed: seed alu_data_MEM=5");
      chk("seed_alu", alu_data_MEM, 32'd5);
      rs1_data_EX = 32'd99; imm_EX = 32'd3; forward_ASel = 2'b01;
      tick();
      $display("directed: MEM forward ADD");
      chk("mem_fwd", alu_data_MEM, 32'd8);
      forward_ASel = 2'b11;
      tick();
      $display("directed: forward code 11");
      chk("fwd_11", alu_data_MEM, 32'd102);

      // WB forward on rs2 into store
      set_idle();
      wb_data_WB = 32'hDEAD_BEEF; forward_BSel = 2'b10; mem_wren_EX = 1'b1; rs2_data_EX = 32'h1234;
      tick();
      $display("directed: WB forward store");
      chk("wb_store", store_data_MEM, 32'hDEAD_BEEF);
      chk("wb_store_wren", 32'(mem_wren_MEM), 32'd1);

      // Branches
      set_idle();
      instr_EX = 32'h0000_4063; rs1_data_EX = 32'hFFFF_FFFF; rs2_data_EX = 32'd1;
      pc_EX = 32'h100; imm_EX = 32'h20;
      #1;
      $display("directed: BLT -1 < 1");
      chk("blt_taken", 32'(br_taken_EX), 32'd1);
      chk("blt_target", br_target_EX, 32'h120);
      instr_EX = 32'h0000_6063;
      #1;
      $display("directed: BLTU 0xFFFFFFFF < 1");
      chk("bltu_taken", 32'(br_taken_EX), 32'd0);
      instr_EX = 32'h0000_0067; rs1_data_EX = 32'h203; imm_EX = 32'h0;
      #1;
      $display("directed: JALR");
      chk("jalr_taken", 32'(br_taken_EX), 32'd1);
      chk("jalr_target", br_target_EX, 32'h202);
      tick();
      chk("jalr_link", alu_data_MEM, 32'h104);
      instr_EX = 32'h0000_006F; pc_EX = 32'h300; imm_EX = 32'h40;
      #1;
      $display("directed: JAL");
      chk("jal_target", br_target_EX, 32'h340);
      tick();
      chk("jal_link", alu_data_MEM, 32'h304);

      // Stall / flush
      set_idle();
      rs1_data_EX = 32'h11; imm_EX = 32'h22; b_sel_EX = 1'b1; pc_EX = 32'h400; rd_wren_EX = 1'b1;
      tick();
      stall = 1'b1; rs1_data_EX = 32'h99; pc_EX = 32'h500;
      tick(); tick();
      $display("directed: stall 2 cycles");
      chk("stall_alu", alu_data_MEM, 32'h33);
      chk("stall_pc", pc_MEM, 32'h400);
      chk("stall_rd", 32'(rd_wren_MEM), 32'd1);
      stall = 1'b0;
      tick();
      chk("release_alu", alu_data_MEM, 32'hBB);
      stall = 1'b1; flush = 1'b1; instr_EX = 32'h0000_006F;
      #1;
      $display("directed: stall+flush");
      chk("flush_no_br", 32'(br_taken_EX), 32'd0);
      tick();
      chk("flush_instr", instr_MEM, 32'h0000_0013);
      chk("flush_valid", 32'(valid_MEM), 32'd0);
      chk("flush_alu", alu_data_MEM, 32'd0);
      set_idle();
      valid_EX = 1'b0; rd_wren_EX = 1'b1; mem_wren_EX = 1'b1;
      tick();
      $display("directed: invalid slot");
      chk("inv_rd", 32'(rd_wren_MEM), 32'd0);
      chk("inv_mem", 32'(mem_wren_MEM), 32'd0);

      // ALU boundaries
      set_idle();
      rs1_data_EX = 32'h7FFF_FFFF; imm_EX = 32'd1; b_sel_EX = 1'b1;
      tick();
      $display("directed: ALU boundaries");
      chk("add_wrap", alu_data_MEM, 32'h8000_0000);
      alu_op_EX = ALU_SRA; rs1_data_EX = 32'h8000_0000; imm_EX = 32'd31;
      tick();
      chk("sra31", alu_data_MEM, 32'hFFFF_FFFF);
      alu_op_EX = ALU_SLL; b_sel_EX = 1'b0; rs1_data_EX = 32'd1; rs2_data_EX = 32'd33;
      tick();
      chk("sll33", alu_data_MEM, 32'd2);

      // Reset mid-stall
      set_idle();
      pc_EX = 32'h700; rd_wren_EX = 1'b1;
      tick();
      stall = 1'b1;
      @(posedge clk); #3 rst = 1'b1;
      #1;
      $display("directed: reset mid-stall");
      chk("rst_instr", instr_MEM, 32'h0000_0013);
      chk("rst_pc", pc_MEM, 32'd0);
      chk("rst_valid", 32'(valid_MEM), 32'd0);
      @(negedge clk); #1 rst = 1'b0; stall = 1'b0;

      // Randomized traffic; checked by the per-cycle compare
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         tmp = $urandom;
         case ($urandom_range(0, 9))
            0, 1, 2: opc = 7'b1100011;
            3:       opc = 7'b1101111;
            4:       opc = 7'b1100111;
            5:       opc = tmp[6:0];
            default: opc = 7'b0110011;
         endcase
         instr_EX     = {tmp[31:7], opc};
         pc_EX        = {$urandom_range(0, 32'hFFFF), 2'b00};
         valid_EX     = ($urandom_range(0, 7) != 0);
         rs1_data_EX  = rand_val();
         rs2_data_EX  = rand_val();
         imm_EX       = rand_val();
         wb_data_WB   = rand_val();
         alu_op_EX    = 4'($urandom_range(0, 10));
         a_sel_EX     = ($urandom_range(0, 3) == 0);
         b_sel_EX     = 1'($urandom_range(0, 1));
         rd_wren_EX   = 1'($urandom_range(0, 1));
         mem_wren_EX  = 1'($urandom_range(0, 1));
         wb_sel_EX    = 2'($urandom_range(0, 3));
         forward_ASel = 2'($urandom_range(0, 3));
         forward_BSel = 2'($urandom_range(0, 3));
         stall        = ($urandom_range(0, 4) == 0);
         flush        = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk); #1;
      @(negedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32I pipeline. It consumes the forwarding selects produced by the forward unit and resolves each operand from the register file, the MEM-stage ALU result, or the WB write-back data. It computes the ALU result and branch/jump decision, then registers everything into the EX/MEM pipeline register. Its registered outputs (`instr_MEM`, `rd_wren_MEM`, `alu_data_MEM`) feed back into the forward unit and the memory stage.

## Interface
No parameters (XLEN fixed at 32).
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_EX` in 32: instruction in EX.
- `pc_EX` in 32: its PC.
- `valid_EX` in 1: EX slot holds a real instruction.
- `rs1_data_EX`, `rs2_data_EX` in 32 each: register-file read data.
- `imm_EX` in 32: sign-extended immediate.
- `alu_op_EX` in 4: ALU operation (package enum).
- `a_sel_EX` in 1: operand A select, 0 = rs1 path, 1 = pc.
- `b_sel_EX` in 1: operand B select, 0 = rs2 path, 1 = imm.
- `rd_wren_EX`, `mem_wren_EX` in 1 each: write enables carried forward.
- `wb_sel_EX` in 2: write-back source carried forward.
- `forward_ASel`, `forward_BSel` in 2 each: 00 none, 01 MEM, 10 WB, 11 treated as none.
- `wb_data_WB` in 32: WB-stage write-back value.
- `stall` in 1: hold the EX/MEM register.
- `flush` in 1: load a bubble into the EX/MEM register.
- `br_taken_EX` out 1: redirect request (combinational).
- `br_target_EX` out 32: redirect address (combinational).
- `instr_MEM`, `pc_MEM`, `alu_data_MEM`, `store_data_MEM` out 32 each: registered.
- `rd_wren_MEM`, `mem_wren_MEM`, `valid_MEM` out 1 each: registered.
- `wb_sel_MEM` out 2: registered.

## Operation
- **Forwarded rs1 (`fwd_a`):** `alu_data_MEM` if sel=01; `wb_data_WB` if sel=10; else `rs1_data_EX`. `fwd_b` is built the same way from `rs2_data_EX`.
- **ALU operands:**
  - opA = `a_sel_EX ? pc_EX : fwd_a`
  - opB = `b_sel_EX ? imm_EX : fwd_b`
- **ALU ops:** ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B (for LUI).
  - Shifts use opB[4:0].
  - Arithmetic wraps modulo 2^32.
  - SLT is signed; SLTU is unsigned.
- **Branch (opcode 1100011):** compares `fwd_a` against `fwd_b` per funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU). Target = `pc_EX + imm_EX`.
- **JAL:** taken; target = `pc_EX + imm_EX`.
- **JALR:** taken; target = (`fwd_a + imm_EX`) & ~1.
- **Link value:** for JAL and JALR, `alu_data_MEM` captures `pc_EX + 4`.
- **Branch gating:** `br_taken_EX` is forced to 0 when `valid_EX` = 0 or `flush` = 1.
- **Store data:** `store_data_MEM` captures `fwd_b` (forwarded rs2), never imm.
- **EX/MEM register:**
  - Flush takes priority over stall.
  - On flush: load the bubble (`instr_MEM` = 32'h0000_0013, all enables 0, `valid_MEM` = 0, data fields 0).
  - On stall: hold all fields.
  - Otherwise: capture.
  - When `valid_EX` = 0, capture with `rd_wren_MEM` and `mem_wren_MEM` forced to 0.

## Timing
- **Reset:** asynchronous assert clears the EX/MEM register immediately to the bubble state:
  - `instr_MEM` = 32'h0000_0013
  - `pc_MEM`, `alu_data_MEM`, `store_data_MEM` = 0
  - `rd_wren_MEM`, `mem_wren_MEM`, `valid_MEM` = 0
  - `wb_sel_MEM` = 0
- **Reset release:** takes effect on the first rising edge after deassert.
- **Combinational paths:** `br_taken_EX` and `br_target_EX` are valid in the same cycle as the EX inputs.
- **Register latency:** EX inputs appear on `*_MEM` after exactly one edge.
- **MEM feedback:** the MEM forwarding source is this block's own registered `alu_data_MEM`. It is a combinational path from register output to operand mux, with no loop through the register.
- **Stall and flush together:** the bubble is loaded.
- **Stall released:** the held value advances on the next edge.
- **Reset mid-stall:** reset wins; no held state survives.

## Structure
- **Shared package `riscv_pkg`:**
  - forward codes `NO_FORWARD` / `MEM_FORWARD` / `WB_FORWARD`
  - `alu_op_e` enum
  - `NOP_INSTR` = 32'h0000_0013
  - opcode constants (BRANCH, JAL, JALR)
  - `wb_sel` encoding
- **Sub-module `alu`:** a purely combinational ALU (opA, opB, op → result).
- **Top level:** operand muxes, branch compare, and the EX/MEM register.

## Test plan
- **Reset:** rst=1 mid-run, asynchronous → outputs show the bubble before the next edge (`instr_MEM`=0x00000013, `valid_MEM`=0).
- **MEM forward:**
  - Setup: `alu_data_MEM`=5, `rs1_data_EX`=99, ADD, b_sel=imm, imm=3, forward_ASel=01.
  - Expected: next edge `alu_data_MEM`=8.
  - Repeat with sel=11 → 102.
- **WB forward on rs2 into store:**
  - Setup: `wb_data_WB`=0xDEADBEEF, forward_BSel=10, `mem_wren_EX`=1.
  - Expected: `store_data_MEM`=0xDEADBEEF.
- **Branch:**
  - BLT with `fwd_a`=-1, `fwd_b`=1, pc=0x100, imm=0x20 → `br_taken_EX`=1, target=0x120.
  - BLTU with the same operands → not taken.
  - JALR with rs1=0x203, imm=0 → target=0x202, `alu_data_MEM`=pc+4.
- **Stall/flush:**
  - stall=1 for 2 cycles → outputs held.
  - stall=1 with flush=1 → bubble.
  - valid_EX=0 with rd_wren_EX=1 → `rd_wren_MEM`=0.
- **ALU boundaries:**
  - 0x7FFFFFFF+1 → 0x80000000.
  - SRA 0x80000000 by 31 → 0xFFFFFFFF.
  - SLL by opB=33 → shift by 1.
